// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg.sv
// Shared types and limits for the staged reset-release sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg;

    // Largest supported number of staged outputs and release spacing.
    localparam int NOUT_MAX = 16;
    localparam int HOLD_MAX = 256;

    // Sequencer state: waiting on the synchronizer, releasing stages, or all released.
    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        STAGE     = 2'd1,
        READY     = 2'd2
    } rstseq_state_t;

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstsync.sv
// Reset-release synchronizer: SYNC falling-edge flops with async active-low clear.
// Latency: rn_sync rises on the SYNC-th falling CLKN edge after RN rises; RN low clears at once.
// Backpressure: none.
module gf180mcu_fd_sc_mcu9t5v0__rstsync #(
    parameter int SYNC = 2
) (
    input  logic CLKN,
    input  logic RN,
    output logic rn_sync,
    output logic rn_sync_d
);

    if (SYNC < 2 || SYNC > 3) begin : g_bad_sync
        $error("rstsync: SYNC must be 2 or 3");
    end

    logic [SYNC-1:0] chain;

    // Shift a constant 1 through the chain; every flop clears asynchronously with RN.
    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC-2:0], 1'b1};
        end
    end

    // rn_sync_d is the value the last flop takes on the coming edge, so the
    // sequencer can act on the very edge where rn_sync rises.
    assign rn_sync   = chain[SYNC-1];
    assign rn_sync_d = chain[SYNC-2];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// Staged reset-release sequencer: releases NOUT active-low resets one by one, HOLD edges apart.
// Latency: RN_OUT[k] rises HOLD*(k+1) falling edges after STAGE entry; RN low clears outputs at once.
// Backpressure: none; REQ is honoured only in READY, ignored while sequencing.
module gf180mcu_fd_sc_mcu9t5v0__rstseq
    import gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg::*;
#(
    parameter int NOUT = 4,
    parameter int HOLD = 8,
    parameter int SYNC = 2
) (
    input  logic            CLKN,
    input  logic            RN,
    input  logic            REQ,
    output logic [NOUT-1:0] RN_OUT,
    output logic            BUSY,
    output logic            DONE
);

    if (NOUT < 1 || NOUT > NOUT_MAX) begin : g_bad_nout
        $error("rstseq: NOUT out of range 1..16");
    end
    if (HOLD < 1 || HOLD > HOLD_MAX) begin : g_bad_hold
        $error("rstseq: HOLD out of range 1..256");
    end

    localparam int CW = width_of(HOLD);
    localparam int IW = width_of(NOUT);

    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NOUT - 1);

    rstseq_state_t   state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [NOUT-1:0] rn_out_q;
    logic            done_q;
    logic [NOUT-1:0] idx_bit;

    logic rn_sync;
    logic rn_sync_d;
    logic go;

    gf180mcu_fd_sc_mcu9t5v0__rstsync #(
        .SYNC (SYNC)
    ) u_sync (
        .CLKN      (CLKN),
        .RN        (RN),
        .rn_sync   (rn_sync),
        .rn_sync_d (rn_sync_d)
    );

    // Synchronized release lands on this edge.
    assign go      = rn_sync_d & ~rn_sync;
    assign idx_bit = NOUT'(1) << idx;

    // Sequencer: wait for synchronized release, then open one stage every HOLD edges.
    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            state    <= SYNC_WAIT;
            cnt      <= '0;
            idx      <= '0;
            rn_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                SYNC_WAIT: begin
                    if (go) begin
                        state <= STAGE;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                STAGE: begin
                    if (cnt == CNT_LAST) begin
                        rn_out_q <= rn_out_q | idx_bit;
                        cnt      <= '0;
                        // idx stops at the last stage rather than wrapping.
                        if (idx == IDX_LAST) begin
                            state  <= READY;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                READY: begin
                    // Software re-reset: synchronizer stays set, so staging restarts at this edge.
                    if (REQ) begin
                        state    <= STAGE;
                        cnt      <= '0;
                        idx      <= '0;
                        rn_out_q <= '0;
                        done_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= SYNC_WAIT;
                end
            endcase
        end
    end

    assign RN_OUT = rn_out_q;
    assign DONE   = done_q;
    assign BUSY   = ~done_q;

endmodule
